led_frame_buffer: RTL and testbench

//  Double-buffered 4x8 bitmap store that feeds the LED matrix scanner's four 8-bit row inputs.

---
 rtl/led_frame_buffer.sv | 96 +++++++++
 tb/tb_led_frame_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
// Double-buffered 4x8 bitmap store for the LED matrix scanner. Rows are written into a back
// buffer and copied to the displayed front buffer only on a frame-start strobe after a commit.
module led_frame_buffer #(
  parameter logic [7:0] ROWS_RESET = 8'h00,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [1:0]         i_wr_addr,
  input  logic [7:0]         i_wr_data,
  input  logic               i_commit,
  output logic               o_commit_pending,
  input  logic               i_frame_start,
  output logic [7:0]         o_row0,
  output logic [7:0]         o_row1,
  output logic [7:0]         o_row2,
  output logic [7:0]         o_row3,
  output logic               o_swap,
  output logic [COUNT_W-1:0] o_swap_count
);

  // Write handshake: a row is stored on any rising edge where i_wr_valid and o_wr_ready are
  // both high; o_wr_ready is low while a commit is pending, and writes offered then are dropped.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_swap;
  logic               w_wr_accept;
  logic [7:0]         r_back  [4];
  logic [7:0]         r_front [4];
  logic               r_swap;
  logic [COUNT_W-1:0] r_swap_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A strobe only swaps when the commit was already registered, so commit-to-swap is >= 1 cycle.
  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_commit) w_state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (i_frame_start) begin
          w_state_next = ST_IDLE;
          w_swap       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_wr_accept = i_wr_valid && (r_state == ST_IDLE);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_back[i]  <= ROWS_RESET;
        r_front[i] <= ROWS_RESET;
      end
      r_swap       <= 1'b0;
      r_swap_count <= '0;
    end else begin
      if (w_wr_accept) r_back[i_wr_addr] <= i_wr_data;
      // Back buffer is left intact after the copy so producers can make incremental edits.
      if (w_swap) begin
        for (int i = 0; i < 4; i++) r_front[i] <= r_back[i];
        r_swap_count <= r_swap_count + 1'b1;
      end
      r_swap <= w_swap;
    end
  end

  assign o_commit_pending = (r_state == ST_PENDING);
  assign o_wr_ready       = (r_state == ST_IDLE);
  assign o_row0           = r_front[0];
  assign o_row1           = r_front[1];
  assign o_row2           = r_front[2];
  assign o_row3           = r_front[3];
  assign o_swap           = r_swap;
  assign o_swap_count     = r_swap_count;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: inputs change 1 ns after a rising edge and outputs
// are checked at that same point, reflecting the edge just taken.
module tb_led_frame_buffer;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       frame_start;
  logic [7:0] row0, row1, row2, row3;
  logic       swap;
  logic [7:0] swap_count;

  int n_cmp  = 0;
  int n_fail = 0;

  led_frame_buffer #(
    .ROWS_RESET (8'h00),
    .COUNT_W    (8)
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_wr_valid       (wr_valid),
    .o_wr_ready       (wr_ready),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .i_commit         (commit),
    .o_commit_pending (commit_pending),
    .i_frame_start    (frame_start),
    .o_row0           (row0),
    .o_row1           (row1),
    .o_row2           (row2),
    .o_row3           (row3),
    .o_swap           (swap),
    .o_swap_count     (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rows(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".row0"}, 32'(row0), 32'(e0));
    chk({tag, ".row1"}, 32'(row1), 32'(e1));
    chk({tag, ".row2"}, 32'(row2), 32'(e2));
    chk({tag, ".row3"}, 32'(row3), 32'(e3));
  endtask

  task automatic write_row(input logic [1:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = 2'd0;
    wr_data     = 8'h00;
    commit      = 1'b0;
    frame_start = 1'b0;
    #23;

    // 1: reset state
    chk_rows("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.wr_ready", 32'(wr_ready), 32'd1);
    chk("reset.pending", 32'(commit_pending), 32'd0);
    chk("reset.swap", 32'(swap), 32'd0);
    chk("reset.count", 32'(swap_count), 32'd0);
    rst_n = 1'b1;
    step();

    // 2: writes without commit, then a strobe has no effect
    write_row(2'd0, 8'hA5);
    write_row(2'd1, 8'h3C);
    write_row(2'd2, 8'hFF);
    write_row(2'd3, 8'h01);
    pulse_frame();
    chk_rows("nocommit", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("nocommit.swap", 32'(swap), 32'd0);
    chk("nocommit.count", 32'(swap_count), 32'd0);

    // 3: commit, strobe two cycles later, swap visible next cycle
    pulse_commit();
    chk("commit.pending", 32'(commit_pending), 32'd1);
    chk("commit.wr_ready", 32'(wr_ready), 32'd0);
    chk_rows("commit.noswap", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    pulse_frame();
    chk_rows("swap1", 8'hA5, 8'h3C, 8'hFF, 8'h01);
    chk("swap1.swap", 32'(swap), 32'd1);
    chk("swap1.count", 32'(swap_count), 32'd1);
    chk("swap1.wr_ready", 32'(wr_ready), 32'd1);
    step();
    chk("swap1.swap_drop", 32'(swap), 32'd0);
    chk_rows("swap1.hold", 8'hA5, 8'h3C, 8'hFF, 8'h01);

    // 4: write while pending is dropped
    pulse_commit();
    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_data  = 8'h77;
    chk("pendwr.wr_ready", 32'(wr_ready), 32'd0);
    step();
    wr_valid = 1'b0;
    pulse_frame();
    chk_rows("pendwr.swap", 8'hA5, 8'h3C, 8'hFF, 8'h01);
    chk("pendwr.count", 32'(swap_count), 32'd2);

    // 5: write + commit + strobe together: write kept, pending set, no swap yet
    wr_valid    = 1'b1;
    wr_addr     = 2'd0;
    wr_data     = 8'h5A;
    commit      = 1'b1;
    frame_start = 1'b1;
    step();
    wr_valid    = 1'b0;
    commit      = 1'b0;
    frame_start = 1'b0;
    chk("same.swap", 32'(swap), 32'd0);
    chk("same.pending", 32'(commit_pending), 32'd1);
    chk("same.row0", 32'(row0), 32'h A5);
    chk("same.count", 32'(swap_count), 32'd2);
    // a repeated commit while pending must not add a second swap
    pulse_commit();
    pulse_frame();
    chk_rows("same.swap2", 8'h5A, 8'h3C, 8'hFF, 8'h01);
    chk("same.swap2.swap", 32'(swap), 32'd1);
    chk("same.swap2.count", 32'(swap_count), 32'd3);
    pulse_frame();
    chk("same.extra.swap", 32'(swap), 32'd0);
    chk("same.extra.count", 32'(swap_count), 32'd3);

    // 6: wrap the swap counter 255 -> 0
    for (int i = 0; i < 252; i++) begin
      pulse_commit();
      pulse_frame();
    end
    chk("wrap.count255", 32'(swap_count), 32'd255);
    pulse_commit();
    pulse_frame();
    chk("wrap.count0", 32'(swap_count), 32'd0);
    chk("wrap.swap", 32'(swap), 32'd1);

    // async reset while pending, mid-cycle
    write_row(2'd1, 8'hEE);
    pulse_commit();
    chk("prerst.pending", 32'(commit_pending), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rows("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("arst.pending", 32'(commit_pending), 32'd0);
    chk("arst.wr_ready", 32'(wr_ready), 32'd1);
    chk("arst.swap", 32'(swap), 32'd0);
    chk("arst.count", 32'(swap_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse_frame();
    chk("postrst.swap", 32'(swap), 32'd0);
    pulse_commit();
    pulse_frame();
    chk_rows("postrst.swap", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("postrst.count", 32'(swap_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
